// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for a simple in-order fetch front end. Each
// advance moves the PC to the next sequential word, to a JAL/branch target
// (pc + offset) or to a JALR target ((rs1 + offset) with bit 0 cleared). When
// a sequential advance happens at HALT_ADDR, the sequencer enters HALT. It
// stays there until reset.
//
// An advance happens on a rising edge when all of these hold: the state is
// RUN, fetch_ready is high and stall is low. The control inputs are only
// looked at in that cycle.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   defined   - a redirect target that is not word aligned sends the PC to
//               TRAP_VECTOR. trap pulses high for one cycle and trap_pc
//               captures the faulting target.
//   undefined - redirect targets are forced to word alignment. The trap and
//               trap_pc ports are not present.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   target_sel   in   2  00 seq/branch, 01 pc+offset, 10 rs1+offset, 11 = 00
//   branch_taken in   1  conditional branch resolved taken
//   offset       in   XLEN sign-extended immediate
//   rs1_data     in   XLEN JALR base register
//   stall        in   1  pipeline hold (dominates fetch_ready)
//   fetch_ready  in   1  fetch accepts the current pc
//   pc           out  XLEN registered current PC
//   pc_valid     out  1  pc offered to fetch (RUN only)
//   halted       out  1  sequencer in HALT
//   trap         out  1  misalign pulse        (PC_MISALIGN_TRAP_EN only)
//   trap_pc      out  XLEN faulting target     (PC_MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0,
   parameter logic [XLEN-1:0] HALT_ADDR    = 32'h94,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h100
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      target_sel,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] rs1_data,
   input  logic            stall,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic            halted
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic            trap,
   output logic [XLEN-1:0] trap_pc
`endif
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              advance;
   logic              redirect;
   logic [XLEN-1:0]   raw_target;

`ifdef PC_MISALIGN_TRAP_EN
   logic              trap_q, trap_d;
   logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
   logic              misalign;
`endif

   // JALR drops bit 0 of the computed address.
   function automatic logic [XLEN-1:0] clear_lsb(input logic [XLEN-1:0] a);
      return a & ~XLEN'(1);
   endfunction

   // Force a target onto a word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

   // pc_valid is decoded from registered state, so checking RUN is enough here.
   assign advance = (state_q == RUN) && fetch_ready && !stall;

   // ---- state register -------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         pc_q      <= RESET_VECTOR;
`ifdef PC_MISALIGN_TRAP_EN
         trap_q    <= 1'b0;
         trap_pc_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
`ifdef PC_MISALIGN_TRAP_EN
         trap_q    <= trap_d;
         trap_pc_q <= trap_pc_d;
`endif
      end
   end

   // ---- next-state / next-pc -------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redirect   = 1'b0;
      raw_target = pc_q + offset;
`ifdef PC_MISALIGN_TRAP_EN
      misalign   = 1'b0;
      trap_d     = 1'b0;
      trap_pc_d  = trap_pc_q;
`endif
      if (advance) begin
         case (target_sel)
            2'b01: redirect = 1'b1;
            2'b10: begin
               redirect   = 1'b1;
               raw_target = clear_lsb(rs1_data + offset);
            end
            default: redirect = branch_taken;
         endcase

         // A jump or a taken branch overrides the halt check.
         if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
            misalign = (raw_target[1:0] != 2'b00);
            if (misalign) begin
               pc_d      = TRAP_VECTOR;
               trap_d    = 1'b1;
               trap_pc_d = raw_target;
            end else begin
               pc_d = raw_target;
            end
`else
            pc_d = word_align(raw_target);
`endif
         end else if (pc_q == HALT_ADDR) begin
            state_d = HALT;
         end else begin
            pc_d = pc_q + XLEN'(4);
         end
      end
   end

   // ---- outputs --------------------------------------------------------------
   always_comb begin
      pc       = pc_q;
      pc_valid = (state_q == RUN);
      halted   = (state_q == HALT);
`ifdef PC_MISALIGN_TRAP_EN
      trap     = trap_q;
      trap_pc  = trap_pc_q;
`endif
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Scoreboard bench for pc_sequencer (default parameters). A driver applies
// one input set per cycle. For each set it computes the expected state after
// the next edge with an arithmetic reference model and queues it. A monitor
// process pops one entry after each edge and compares. Build with
// +define+PC_MISALIGN_TRAP_EN to cover the trap variant.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam logic [31:0] RESET_VECTOR = 32'h0;
   localparam logic [31:0] HALT_ADDR    = 32'h94;
   localparam logic [31:0] TRAP_VECTOR  = 32'h100;
   localparam longint      MOD          = longint'(1) << 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  target_sel = 2'b00;
   logic        branch_taken = 1'b0;
   logic [31:0] offset = '0;
   logic [31:0] rs1_data = '0;
   logic        stall = 1'b0;
   logic        fetch_ready = 1'b0;
   logic [31:0] pc;
   logic        pc_valid;
   logic        halted;
   logic        trap;
   logic [31:0] trap_pc;

   pc_sequencer #(
      .XLEN(32), .RESET_VECTOR(RESET_VECTOR), .HALT_ADDR(HALT_ADDR), .TRAP_VECTOR(TRAP_VECTOR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .target_sel(target_sel), .branch_taken(branch_taken),
      .offset(offset), .rs1_data(rs1_data), .stall(stall), .fetch_ready(fetch_ready),
      .pc(pc), .pc_valid(pc_valid), .halted(halted)
`ifdef PC_MISALIGN_TRAP_EN
      , .trap(trap), .trap_pc(trap_pc)
`endif
   );

`ifndef PC_MISALIGN_TRAP_EN
   assign trap    = 1'b0;
   assign trap_pc = '0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        vld;
      logic        hlt;
      logic        trp;
      logic [31:0] trp_pc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_halted;
   logic [31:0] m_trap_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: one expected entry is consumed after each rising edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_valid", 32'(pc_valid), 32'(e.vld));
            chk("halted", 32'(halted), 32'(e.hlt));
`ifdef PC_MISALIGN_TRAP_EN
            chk("trap", 32'(trap), 32'(e.trp));
            chk("trap_pc", trap_pc, e.trp_pc);
`endif
         end
      end
   end

   // Applies one input set at a mid-cycle slot. Updates the model and queues
   // the expected result of the coming edge, then moves to the next slot.
   task automatic drive(input logic [1:0] sel, input logic br, input logic [31:0] off,
                        input logic [31:0] rs1, input logic st, input logic fr);
      exp_t   e;
      longint t;
      bit     redir;
      target_sel   = sel;
      branch_taken = br;
      offset       = off;
      rs1_data     = rs1;
      stall        = st;
      fetch_ready  = fr;
      e.trp = 1'b0;
      t     = 0;
      if (!m_halted && fr && !st) begin
         redir = 1'b1;
         if (sel == 2'b01)
            t = (longint'(m_pc) + longint'(off)) % MOD;
         else if (sel == 2'b10) begin
            t = (longint'(rs1) + longint'(off)) % MOD;
            t = t - (t % 2);
         end else if (br)
            t = (longint'(m_pc) + longint'(off)) % MOD;
         else begin
            redir = 1'b0;
            if (m_pc == HALT_ADDR) m_halted = 1'b1;
            else m_pc = 32'((longint'(m_pc) + 4) % MOD);
         end
         if (redir) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
               e.trp     = 1'b1;
               m_trap_pc = 32'(t);
               m_pc      = TRAP_VECTOR;
            end else m_pc = 32'(t);
`else
            m_pc = 32'(t - (t % 4));
`endif
         end
      end
      e.pc     = m_pc;
      e.vld    = !m_halted;
      e.hlt    = m_halted;
      e.trp_pc = m_trap_pc;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Called at a driver slot; the queue is empty at that point.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_pc", pc, RESET_VECTOR);
      chk("rst_pc_valid", 32'(pc_valid), 32'd1);
      chk("rst_halted", 32'(halted), 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_trap_pc", trap_pc, 32'd0);
`endif
      repeat (2) @(posedge clk);
      #2;
      rst_n     = 1'b1;
      m_pc      = RESET_VECTOR;
      m_halted  = 1'b0;
      m_trap_pc = '0;
   endtask

   initial begin : stim
      logic [1:0]  sel;
      logic [31:0] off;
      m_pc = RESET_VECTOR; m_halted = 1'b0; m_trap_pc = '0;
      repeat (2) @(posedge clk);
      #2;
      do_reset();

      // Sequential run: 4, 8, C, 10
      for (int i = 0; i < 4; i++) drive(2'b00, 1'b0, '0, '0, 1'b0, 1'b1);
      // JAL +0x20 held by stall for 3 cycles (fetch_ready high throughout)
      for (int i = 0; i < 3; i++) drive(2'b01, 1'b0, 32'h20, '0, 1'b1, 1'b1);
      drive(2'b01, 1'b0, 32'h20, '0, 1'b0, 1'b1);             // -> 0x30
      drive(2'b00, 1'b0, '0, '0, 1'b0, 1'b0);                  // no fetch_ready
      drive(2'b01, 1'b0, 32'h10, '0, 1'b0, 1'b1);              // -> 0x40
      drive(2'b10, 1'b0, 32'h0, 32'h203, 1'b0, 1'b1);          // JALR 0x203
      drive(2'b00, 1'b0, '0, '0, 1'b0, 1'b1);                  // trap clears
      drive(2'b11, 1'b0, 32'h40, '0, 1'b0, 1'b1);              // sel 11 = seq
      drive(2'b01, 1'b0, 32'hFFFF_FFFC - m_pc, '0, 1'b0, 1'b1); // -> FFFFFFFC
      drive(2'b00, 1'b0, '0, '0, 1'b0, 1'b1);                  // wrap -> 0
      drive(2'b01, 1'b0, 32'h94, '0, 1'b0, 1'b1);              // -> 0x94
      drive(2'b00, 1'b1, 32'hFFFF_FFF8, '0, 1'b0, 1'b1);       // branch -> 0x8C
      drive(2'b00, 1'b1, 32'h6, '0, 1'b0, 1'b1);               // misaligned branch
      drive(2'b01, 1'b0, 32'h8C - m_pc, '0, 1'b0, 1'b1);       // back to 0x8C
      for (int i = 0; i < 6; i++) drive(2'b00, 1'b0, '0, '0, 1'b0, 1'b1); // halt
      drive(2'b01, 1'b1, 32'h20, 32'h20, 1'b0, 1'b1);          // ignored in HALT
      do_reset();
      drive(2'b00, 1'b0, '0, '0, 1'b1, 1'b1);                  // stall
      do_reset();                                              // reset mid-stall
      drive(2'b00, 1'b0, '0, '0, 1'b0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         sel = 2'($urandom_range(0, 3));
         off = 32'($signed($urandom_range(0, 255)) - 128);
         if ($urandom_range(0, 9) == 0) begin
            sel = 2'b01;
            off = 32'h88 - m_pc;
         end
         drive(sel, ($urandom_range(0, 3) == 0), off, 32'($urandom_range(0, 1023)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
         if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0)
            do_reset();
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, PC/data width; RESET_VECTOR, default 32'h0, PC after reset; HALT_ADDR, default 32'h94, halt address; TRAP_VECTOR, default 32'h100, misalign trap target.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 target_sel  input  2  00 sequential/branch, 01 pc+offset (JAL), 10 rs1+offset (JALR), 11 treated as 00.
REQ-005 branch_taken  input  1  conditional branch resolved taken.
REQ-006 offset  input  XLEN  sign-extended immediate.
REQ-007 rs1_data  input  XLEN  JALR base register value.
REQ-008 stall  input  1  pipeline hold request.
REQ-009 fetch_ready  input  1  fetch stage accepts current pc.
REQ-010 pc  output  XLEN  registered current PC.
REQ-011 pc_valid  output  1  pc presented to fetch; 1 only in RUN.
REQ-012 halted  output  1  sequencer in HALT state.
REQ-013 trap  output  1  one-cycle misalign pulse (PC_MISALIGN_TRAP_EN only).
REQ-014 trap_pc  output  XLEN  faulting target address (PC_MISALIGN_TRAP_EN only).

Function
REQ-015 FSM SHALL have two states, RUN and HALT; no other states.
REQ-016 An advance SHALL occur on a rising edge iff state RUN, pc_valid=1, fetch_ready=1, stall=0; otherwise pc and state hold.
REQ-017 stall=1 SHALL dominate fetch_ready=1.
REQ-018 target_sel, branch_taken, offset, rs1_data SHALL be sampled in the advancing cycle only.
REQ-019 Next-PC priority on advance SHALL be: sel 01 -> pc+offset; sel 10 -> (rs1_data+offset) with bit 0 cleared; branch_taken -> pc+offset; pc==HALT_ADDR -> enter HALT, pc held; else pc+4.
REQ-020 Jump/branch SHALL override the halt check (pc==HALT_ADDR with branch_taken=1 redirects, no halt).
REQ-021 All adds SHALL be modulo 2^XLEN (pc=FFFFFFFC +4 -> 00000000).
REQ-022 In HALT: pc held at HALT_ADDR, pc_valid=0, halted=1, until reset.
REQ-023 Latency: new pc visible on pc one cycle after the advancing edge; pc_valid and halted SHALL be decoded from registered state only.

Reset
REQ-024 rst_n low SHALL immediately force pc=RESET_VECTOR, state RUN, pc_valid=1, halted=0, trap=0, trap_pc=0, independent of clk.
REQ-025 Reset asserted mid-stall or in HALT SHALL return to RUN at RESET_VECTOR; first advance possible on first rising edge after rst_n high.

Configuration
REQ-026 Macro PC_MISALIGN_TRAP_EN defined: on advance, if selected redirect target (sel 01/10 or branch) has bits[1:0]!=00, pc SHALL load TRAP_VECTOR, trap SHALL pulse 1 for exactly one cycle, trap_pc SHALL load the faulting target and hold until next trap.
REQ-027 Macro undefined: redirect target bits[1:0] SHALL be forced to 00, no trap; trap and trap_pc ports SHALL not exist.

Verification
REQ-028 Reset release, fetch_ready=1, sel 00, no branch -> pc 0,4,8,... one step per cycle.
REQ-029 pc=0x10, sel 01, offset=0x20, stall=1 for 3 cycles then 0 -> pc holds 0x10 for 3 cycles, then 0x30.
REQ-030 pc=0x40, sel 10, rs1_data=0x203, offset=0 -> pc=0x202 with macro: trap=1, trap_pc=0x202, pc=0x100; without macro: pc=0x200.
REQ-031 Run sequentially to 0x94 -> next advance sets halted=1, pc_valid=0, pc stays 0x94; rst_n pulse low -> pc=0, halted=0.
REQ-032 pc=0xFFFFFFFC, sel 00 -> pc=0x0; pc=0x94, branch_taken=1, offset=-8 -> pc=0x8C, no halt.
